// File: rtl/ps2_port_pkg.sv
// Shared definitions for the PS/2 host port: FSM encodings, keyboard prefix
// bytes and the parity helper used when building a transmit frame.
package ps2_port_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_SHIFT,
      RX_CHECK
   } rx_state_t;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_INHIBIT,
      TX_REQ,
      TX_SHIFT,
      TX_ACK,
      TX_DONE
   } tx_state_t;

   localparam logic [7:0] PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PREFIX_REL = 8'hF0;

   // Bit that makes the nine-bit {parity, data} word contain an odd number of ones.
   function automatic logic odd_parity_bit(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter: the output only
// follows the line after FILTERLEN consecutive samples at the new level.
module ps2_line_filter #(
   parameter int FILTERLEN = 8
) (
   input  logic sysclk,
   input  logic rst,
   input  logic line_in,
   output logic line_filt
);

   localparam int CW = $clog2(FILTERLEN + 1);

   logic          sync_p0;
   logic          sync_p1;
   logic [CW-1:0] run_cnt;

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         sync_p0   <= 1'b1;
         sync_p1   <= 1'b1;
         run_cnt   <= '0;
         line_filt <= 1'b1;
      end else begin
         sync_p0 <= line_in;
         sync_p1 <= sync_p0;
         if (sync_p1 == line_filt) begin
            run_cnt <= '0;
         end else if (run_cnt == CW'(FILTERLEN - 1)) begin
            line_filt <= sync_p1;
            run_cnt   <= '0;
         end else begin
            run_cnt <= run_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_port.sv
// PS/2 host port: receives keyboard frames (with E0/F0 prefix folding) and
// transmits host-to-device bytes over open-drain clock and data lines.
module ps2_port
   import ps2_port_pkg::*;
#(
   parameter int MASTERCLK = 28000000,
   parameter int FILTERLEN = 8
) (
   input  logic       sysclk,
   input  logic       rst,
   inout  wire        clkps2,
   inout  wire        dataps2,
   output logic [7:0] scancode,
   output logic       extended,
   output logic       released,
   output logic       kb_interrupt,
   output logic       rx_error,
   input  logic [7:0] tx_data,
   input  logic       tx_write,
   output logic       busy,
   output logic       tx_error
);

   localparam int RX_TIMEOUT = MASTERCLK / 1000;
   localparam int INHIBIT    = MASTERCLK / 10000;
   localparam int TX_TIMEOUT = (MASTERCLK / 1000) * 15;
   localparam int RX_W       = $clog2(RX_TIMEOUT + 1);
   localparam int INH_W      = $clog2(INHIBIT + 1);
   localparam int TX_W       = $clog2(TX_TIMEOUT + 1);

   rx_state_t        rx_state;
   tx_state_t        tx_state;
   logic             clk_f;
   logic             data_f;
   logic             clk_f_q;
   logic             clk_fall;
   logic             rx_start;
   logic             tx_accept;
   logic             drive_clk;
   logic             drive_data;
   logic [9:0]       rx_sr;
   logic [3:0]       rx_bits;
   logic [RX_W-1:0]  rx_tmr;
   logic             ext_flag;
   logic             rel_flag;
   logic [8:0]       tx_sr;
   logic [3:0]       tx_bits;
   logic [INH_W-1:0] inh_cnt;
   logic [TX_W-1:0]  tx_tmr;

   // Lines are only ever pulled low or released.
   assign clkps2  = drive_clk  ? 1'b0 : 1'bz;
   assign dataps2 = drive_data ? 1'b0 : 1'bz;

   ps2_line_filter #(.FILTERLEN(FILTERLEN)) u_clk_filt (
      .sysclk    (sysclk),
      .rst       (rst),
      .line_in   (clkps2),
      .line_filt (clk_f)
   );

   ps2_line_filter #(.FILTERLEN(FILTERLEN)) u_data_filt (
      .sysclk    (sysclk),
      .rst       (rst),
      .line_in   (dataps2),
      .line_filt (data_f)
   );

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) clk_f_q <= 1'b1;
      else     clk_f_q <= clk_f;
   end

   assign clk_fall  = clk_f_q & ~clk_f;
   assign rx_start  = (rx_state == RX_IDLE) && (tx_state == TX_IDLE) && clk_fall && !data_f;
   assign busy      = (rx_state != RX_IDLE) || (tx_state != TX_IDLE);
   // A frame starting in the same cycle takes priority over a send request.
   assign tx_accept = tx_write && !busy && !rx_start;

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         rx_state     <= RX_IDLE;
         rx_sr        <= '0;
         rx_bits      <= '0;
         rx_tmr       <= '0;
         ext_flag     <= 1'b0;
         rel_flag     <= 1'b0;
         scancode     <= '0;
         extended     <= 1'b0;
         released     <= 1'b0;
         kb_interrupt <= 1'b0;
         rx_error     <= 1'b0;
      end else begin
         kb_interrupt <= 1'b0;
         rx_error     <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_start) begin
                  rx_state <= RX_SHIFT;
                  rx_bits  <= '0;
                  rx_tmr   <= '0;
               end
            end
            RX_SHIFT: begin
               if (clk_fall) begin
                  rx_sr  <= {data_f, rx_sr[9:1]};
                  rx_tmr <= '0;
                  if (rx_bits == 4'd9) rx_state <= RX_CHECK;
                  else                 rx_bits  <= rx_bits + 1'b1;
               end else if (rx_tmr == RX_W'(RX_TIMEOUT - 1)) begin
                  rx_error <= 1'b1;
                  ext_flag <= 1'b0;
                  rel_flag <= 1'b0;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_tmr <= rx_tmr + 1'b1;
               end
            end
            RX_CHECK: begin
               rx_state <= RX_IDLE;
               if (rx_sr[9] && (^rx_sr[8:0])) begin
                  if (rx_sr[7:0] == PREFIX_EXT) begin
                     ext_flag <= 1'b1;
                  end else if (rx_sr[7:0] == PREFIX_REL) begin
                     rel_flag <= 1'b1;
                  end else begin
                     scancode     <= rx_sr[7:0];
                     extended     <= ext_flag;
                     released     <= rel_flag;
                     kb_interrupt <= 1'b1;
                     ext_flag     <= 1'b0;
                     rel_flag     <= 1'b0;
                  end
               end else begin
                  rx_error <= 1'b1;
                  ext_flag <= 1'b0;
                  rel_flag <= 1'b0;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         tx_state   <= TX_IDLE;
         tx_sr      <= '0;
         tx_bits    <= '0;
         inh_cnt    <= '0;
         tx_tmr     <= '0;
         drive_clk  <= 1'b0;
         drive_data <= 1'b0;
         tx_error   <= 1'b0;
      end else begin
         tx_error <= 1'b0;
         if (tx_state != TX_IDLE) tx_tmr <= tx_tmr + 1'b1;
         if (tx_state != TX_IDLE && tx_tmr == TX_W'(TX_TIMEOUT - 1)) begin
            tx_state   <= TX_IDLE;
            drive_clk  <= 1'b0;
            drive_data <= 1'b0;
            tx_error   <= 1'b1;
         end else begin
            case (tx_state)
               TX_IDLE: begin
                  if (tx_accept) begin
                     tx_sr     <= {odd_parity_bit(tx_data), tx_data};
                     tx_bits   <= '0;
                     inh_cnt   <= '0;
                     tx_tmr    <= '0;
                     drive_clk <= 1'b1;
                     tx_state  <= TX_INHIBIT;
                  end
               end
               TX_INHIBIT: begin
                  if (inh_cnt == INH_W'(INHIBIT - 1)) begin
                     drive_clk  <= 1'b0;
                     drive_data <= 1'b1;
                     tx_state   <= TX_REQ;
                  end else begin
                     inh_cnt <= inh_cnt + 1'b1;
                  end
               end
               TX_REQ: tx_state <= TX_SHIFT;
               TX_SHIFT: begin
                  // Ones shift in behind the word, so the tenth bit is the stop (released) level.
                  if (clk_fall) begin
                     drive_data <= ~tx_sr[0];
                     tx_sr      <= {1'b1, tx_sr[8:1]};
                     if (tx_bits == 4'd9) tx_state <= TX_ACK;
                     else                 tx_bits  <= tx_bits + 1'b1;
                  end
               end
               TX_ACK: begin
                  if (clk_fall) begin
                     if (!data_f) begin
                        tx_state <= TX_DONE;
                     end else begin
                        tx_error <= 1'b1;
                        tx_state <= TX_IDLE;
                     end
                  end
               end
               TX_DONE: begin
                  if (clk_f && data_f) tx_state <= TX_IDLE;
               end
               default: tx_state <= TX_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_port.sv
// Bench for ps2_port: a PS/2 device model drives random keyboard frames and
// answers host transmissions; a scoreboard checks every output pulse.
module tb_ps2_port;

   localparam int MCLK = 1000000;
   localparam int FLEN = 8;
   localparam int RX_T = MCLK / 1000;
   localparam int INH  = MCLK / 10000;
   localparam int TX_T = MCLK * 15 / 1000;

   localparam int EV_KB = 0;
   localparam int EV_RX = 1;
   localparam int EV_TX = 2;

   typedef struct {
      int         kind;
      logic [7:0] code;
      logic       ext;
      logic       rel;
   } ev_t;

   logic       sysclk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_write;
   logic [7:0] scancode;
   logic       extended, released, kb_interrupt, rx_error, busy, tx_error;
   logic       dev_clk_low  = 1'b0;
   logic       dev_data_low = 1'b0;
   wire        ps2_clk;
   wire        ps2_data;

   assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
   assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
   pullup (ps2_clk);
   pullup (ps2_data);

   ps2_port #(.MASTERCLK(MCLK), .FILTERLEN(FLEN)) dut (
      .sysclk       (sysclk),
      .rst          (rst),
      .clkps2       (ps2_clk),
      .dataps2      (ps2_data),
      .scancode     (scancode),
      .extended     (extended),
      .released     (released),
      .kb_interrupt (kb_interrupt),
      .rx_error     (rx_error),
      .tx_data      (tx_data),
      .tx_write     (tx_write),
      .busy         (busy),
      .tx_error     (tx_error)
   );

   always #5 sysclk = ~sysclk;

   int  cyc = 0;
   int  vectors = 0;
   int  miscompares = 0;
   int  half = 20;
   int  last_fall = 0;
   bit  m_ext = 1'b0;
   bit  m_rel = 1'b0;
   ev_t exp_q[$];

   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      vectors++;
      if (act < lo || act > hi) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Keyboard-level reference: prefixes accumulate, a plain byte reports and clears them.
   task automatic model_frame(input logic [7:0] b, input bit good);
      ev_t e;
      if (!good) begin
         e = '{kind: EV_RX, code: 8'h00, ext: 1'b0, rel: 1'b0};
         exp_q.push_back(e);
         m_ext = 1'b0;
         m_rel = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_rel = 1'b1;
      end else begin
         e = '{kind: EV_KB, code: b, ext: m_ext, rel: m_rel};
         exp_q.push_back(e);
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   task automatic pop_check(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_event: got kind %0d, want none", kind);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", kind, e.kind);
         if (kind == EV_KB && e.kind == EV_KB) begin
            check("scancode", scancode, e.code);
            check("extended", extended, e.ext);
            check("released", released, e.rel);
         end
      end
   endtask

   always @(negedge sysclk) begin
      if (!rst) begin
         if (kb_interrupt) pop_check(EV_KB);
         if (rx_error)     pop_check(EV_RX);
         if (tx_error)     pop_check(EV_TX);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic dev_bit(input bit v);
      dev_data_low = !v;
      wait_cyc(half);
      dev_clk_low = 1'b1;
      last_fall   = cyc;
      wait_cyc(half);
      dev_clk_low = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int from, input int to);
      logic [10:0] fr;
      fr[0]   = 1'b0;
      fr[8:1] = b;
      fr[9]   = (($countones(b) % 2) == 0) ^ bad_par;
      fr[10]  = !bad_stop;
      for (int i = from; i < to; i++) dev_bit(fr[i]);
      if (to == 11) dev_data_low = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      model_frame(b, !(bad_par || bad_stop));
      send_bits(b, bad_par, bad_stop, 0, 11);
      wait_cyc(2 * half);
   endtask

   task automatic host_write(input logic [7:0] b);
      wait_cyc(1);
      tx_data  = b;
      tx_write = 1'b1;
      wait_cyc(1);
      tx_write = 1'b0;
   endtask

   task automatic tx_byte(input logic [7:0] d);
      int   n;
      logic bits [10];
      host_write(d);
      check("tx_busy_rise", busy, 1);
      n = 0;
      while (ps2_clk == 1'b0 && n < 2 * INH) begin
         @(negedge sysclk);
         if (ps2_clk == 1'b0) n++;
      end
      check("tx_inhibit_len", n, INH);
      check("tx_rts_data", ps2_data, 0);
      wait_cyc(half);
      for (int i = 0; i < 11; i++) begin
         if (i == 10) dev_data_low = 1'b1;
         dev_clk_low = 1'b1;
         wait_cyc(half);
         if (i < 10) bits[i] = ps2_data;
         dev_clk_low = 1'b0;
         wait_cyc(half);
         if (i == 10) dev_data_low = 1'b0;
      end
      for (int k = 0; k < 8; k++) check($sformatf("tx_bit%0d", k), bits[k], d[k]);
      check("tx_parity", bits[8], ($countones(d) % 2) == 0);
      check("tx_stop", bits[9], 1);
      n = 0;
      while (busy && n < 200) begin
         wait_cyc(1);
         n++;
      end
      check("tx_busy_fall", busy, 0);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      bit         seen;
      logic [7:0] code;
      rst      = 1'b1;
      tx_data  = 8'h00;
      tx_write = 1'b0;
      wait_cyc(3);
      check("rst_scancode", scancode, 0);
      check("rst_extended", extended, 0);
      check("rst_released", released, 0);
      check("rst_kb_int", kb_interrupt, 0);
      check("rst_rx_error", rx_error, 0);
      check("rst_tx_error", tx_error, 0);
      check("rst_busy", busy, 0);
      check("rst_clk_line", ps2_clk, 1);
      check("rst_data_line", ps2_data, 1);
      rst = 1'b0;
      wait_cyc(20);

      rx_byte(8'h1C, 0, 0);
      rx_byte(8'hE0, 0, 0);
      rx_byte(8'hF0, 0, 0);
      rx_byte(8'h75, 0, 0);
      rx_byte(8'h1C, 1, 0);
      check("bad_par_scancode_held", scancode, 8'h75);
      check("bad_par_ext_held", extended, 1);
      rx_byte(8'h1C, 0, 0);
      rx_byte(8'h33, 0, 1);

      // Receive timeout after a truncated frame, then a normal byte.
      model_frame(8'h00, 0);
      send_bits(8'h55, 0, 0, 0, 5);
      dev_data_low = 1'b0;
      n = 0;
      while (!rx_error && n < RX_T + 200) begin
         @(negedge sysclk);
         n++;
      end
      check_range("rx_timeout_delay", cyc - last_fall, RX_T, RX_T + FLEN + 10);
      wait_cyc(5);
      rx_byte(8'h29, 0, 0);

      // Send request during a frame is ignored.
      model_frame(8'h1C, 1);
      send_bits(8'h1C, 0, 0, 0, 3);
      check("busy_mid_frame", busy, 1);
      host_write(8'hAA);
      send_bits(8'h1C, 0, 0, 3, 11);
      wait_cyc(2 * half);
      check("write_ignored_busy", busy, 0);
      check("write_ignored_clk", ps2_clk, 1);

      // Reset in the middle of a frame with a prefix pending.
      rx_byte(8'hE0, 0, 0);
      send_bits(8'h42, 0, 0, 0, 6);
      rst          = 1'b1;
      dev_data_low = 1'b0;
      m_ext        = 1'b0;
      m_rel        = 1'b0;
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(20);
      check("midrst_busy", busy, 0);
      check("midrst_scancode", scancode, 0);
      rx_byte(8'h1C, 0, 0);

      for (int k = 0; k < 20; k++) begin
         half = $urandom_range(15, 30);
         n    = $urandom_range(0, 7);
         if (n == 0) rx_byte(8'hE0, 0, 0);
         if (n == 1) rx_byte(8'hF0, 0, 0);
         code = 8'($urandom);
         rx_byte(code, $urandom_range(0, 9) == 0, 0);
      end

      half = 20;
      tx_byte(8'hED);
      wait_cyc(20);
      tx_byte(8'($urandom));
      wait_cyc(20);

      // Silent device: whole-transmission timeout.
      exp_q.push_back('{kind: EV_TX, code: 8'h00, ext: 1'b0, rel: 1'b0});
      host_write(8'h5A);
      n = 0;
      do begin
         @(negedge sysclk);
         n++;
      end while (!tx_error && n < TX_T + 100);
      check_range("tx_timeout_delay", n, TX_T - 2, TX_T + 3);
      wait_cyc(FLEN + 6);
      check("tx_to_clk_released", ps2_clk, 1);
      check("tx_to_data_released", ps2_data, 1);
      check("tx_to_busy", busy, 0);

      // Single-cycle clock glitch with data low must not start a frame.
      dev_data_low = 1'b1;
      wait_cyc(5);
      dev_clk_low = 1'b1;
      wait_cyc(1);
      dev_clk_low = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge sysclk);
         if (busy) seen = 1'b1;
      end
      check("glitch_no_rx", seen, 0);
      dev_data_low = 1'b0;

      wait_cyc(50);
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
